cen_gen: RTL

CEN_GEN -- requirements
Module: cen_gen

---
 rtl/cen_gen_pkg.sv | 17 +
 rtl/cen_gen_channel.sv | 64 ++++++
 rtl/cen_gen.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cen_gen_pkg.sv
// cen_gen_pkg: FSM state encoding and settle-counter sizing shared by the
// fractional clock-enable generator.
package cen_gen_pkg;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAULT  = 2'd3
  } state_e;

  // Bits needed to count 0 .. lock_cycles-1, never narrower than one bit.
  function automatic int cnt_width(input int lock_cycles);
    return (lock_cycles < 2) ? 1 : $clog2(lock_cycles);
  endfunction

endpackage

// File: rtl/cen_gen_channel.sv
// cen_gen_channel: one fractional-N accumulator producing a clock-enable pulse
// train at clk*num/den. Half-period enable cen_p exists only with CEN_GEN_PHASE_EN.
module cen_gen_channel #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             run,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  output logic             valid,
  output logic             cen,
  output logic             cen_p
);

  // One extra bit: acc < den and num <= den, so acc+num always fits.
  logic [WIDTH:0] acc;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem;
  logic           wrap;
  logic           base_valid;

  assign sum        = acc + {1'b0, num};
  assign wrap       = (sum >= {1'b0, den});
  assign rem        = sum - {1'b0, den};
  assign base_valid = (den != '0) && (num != '0) && (num <= den);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
      cen <= 1'b0;
    end else if (run) begin
      acc <= wrap ? rem : sum;
      cen <= wrap;
    end else begin
      cen <= 1'b0;
    end
  end

`ifdef CEN_GEN_PHASE_EN
  logic [WIDTH:0] half;
  logic           half_hit;

  assign half     = {2'b00, den[WIDTH-1:1]};
  assign half_hit = wrap ? (rem >= half) : ((acc < half) && (sum >= half));
  // A step larger than half a period could skip the half crossing entirely.
  assign valid    = base_valid && (num <= {1'b0, den[WIDTH-1:1]});

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cen_p <= 1'b0;
    end else begin
      cen_p <= run && half_hit;
    end
  end
`else
  assign valid = base_valid;
  assign cen_p = 1'b0;
`endif

endmodule

// File: rtl/cen_gen.sv
// cen_gen: multi-channel fractional clock-enable generator with settle/lock FSM.
// Define CEN_GEN_PHASE_EN to add the half-period-shifted enables on cen_p.
module cen_gen
  import cen_gen_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int WIDTH       = 16,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*WIDTH-1:0] num,
  input  logic [NUM_CH*WIDTH-1:0] den,
  input  logic                    sync,
  output logic [NUM_CH-1:0]       cen,
  output logic [NUM_CH-1:0]       cen_p,
  output logic                    locked
);

  localparam int               CNT_W    = cnt_width(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  state_e                  state;
  state_e                  state_next;
  logic [NUM_CH*WIDTH-1:0] cfg_num;
  logic [NUM_CH*WIDTH-1:0] cfg_den;
  logic [CNT_W-1:0]        cnt;
  logic [NUM_CH-1:0]       valid;
  logic                    cfg_change;
  logic                    all_valid;
  logic                    capture;
  logic                    clr;
  logic                    run;

  assign cfg_change = (num != cfg_num) || (den != cfg_den);
  assign all_valid  = &valid;

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    clr        = 1'b0;
    run        = 1'b0;
    unique case (state)
      ST_RESET: begin
        state_next = ST_SETTLE;
        capture    = 1'b1;
        clr        = 1'b1;
      end
      ST_SETTLE: begin
        if (!all_valid) begin
          state_next = ST_FAULT;
        end else if (cnt == CNT_LAST) begin
          state_next = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        // A new ratio outranks a phase-align request in the same cycle.
        if (cfg_change) begin
          state_next = ST_SETTLE;
          capture    = 1'b1;
          clr        = 1'b1;
        end else if (sync) begin
          clr = 1'b1;
        end else begin
          run = 1'b1;
        end
      end
      ST_FAULT: begin
        if (cfg_change) begin
          state_next = ST_SETTLE;
          capture    = 1'b1;
          clr        = 1'b1;
        end
      end
      default: state_next = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_RESET;
      locked <= 1'b0;
    end else begin
      state  <= state_next;
      locked <= (state_next == ST_LOCKED);
    end
  end

  // NOTE: the config copy is reset because change detection compares against
  // it; a wide register without a reset would make that first compare X.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_num <= '0;
      cfg_den <= '0;
    end else if (capture) begin
      cfg_num <= num;
      cfg_den <= den;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || capture) begin
      cnt <= '0;
    end else if (state == ST_SETTLE) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    cen_gen_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .run   (run),
      .num   (cfg_num[i*WIDTH +: WIDTH]),
      .den   (cfg_den[i*WIDTH +: WIDTH]),
      .valid (valid[i]),
      .cen   (cen[i]),
      .cen_p (cen_p[i])
    );
  end

endmodule
